mult32_controller: RTL and testbench

MULT32_CONTROLLER -- requirements
Module: mult32_controller

---
 rtl/mult32_controller.sv | 142 ++++++++++++++
 tb/tb_mult32_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult32_controller.sv
// rtl/mult32_controller.sv - sequential 32x32 unsigned shift-add multiplier controller
//
// Purpose: multiplies two 32-bit unsigned operands into a 64-bit product with
// a four-state FSM (IDLE, LOAD, CALC, DONE). CALC retires one multiplier bit
// per cycle.
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset_n     in   1   synchronous active-low reset
//   start       in   1   begin a multiply (only sampled in IDLE)
//   a           in  32   multiplicand, captured on the accepting edge
//   b           in  32   multiplier, captured on the accepting edge
//   busy        out  1   high in LOAD, CALC and DONE
//   done        out  1   one-cycle pulse, product valid
//   product_hi  out 32   upper half of the product
//   product_lo  out 32   lower half of the product
//
// Optional feature macro: MULT_EARLY_EXIT_EN
//   When defined, a CALC cycle that starts with no multiplier bits left
//   finishes the pending accumulator shift at once and goes to DONE.

module mult32_controller #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product_hi,
    output logic [31:0] product_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

    state_t      state_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] pp_d;
    logic [32:0] sum_d;

    // Partial product is a plain AND gate array gated by the current LSB.
    assign pp_d  = mcand_q & {32{mplier_q[0]}};
    // 33-bit sum keeps the carry, which becomes the new MSB after the shift.
    assign sum_d = {1'b0, acc_hi_q} + {1'b0, pp_d};

`ifdef MULT_EARLY_EXIT_EN
    logic [6:0]  rem_d;
    logic [63:0] acc_flush_d;

    // Remaining iterations would only add zero, so the accumulator just
    // needs the outstanding right shifts applied in one step.
    assign rem_d       = 7'(ITER) - {1'b0, cnt_q};
    assign acc_flush_d = {acc_hi_q, acc_lo_q} >> rem_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    acc_hi_q <= '0;
                    acc_lo_q <= '0;
                    cnt_q    <= '0;
                    state_q  <= S_CALC;
                end

                S_CALC: begin
`ifdef MULT_EARLY_EXIT_EN
                    if (mplier_q == '0) begin
                        acc_hi_q <= acc_flush_d[63:32];
                        acc_lo_q <= acc_flush_d[31:0];
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
`endif
                        // {carry, acc_hi_next, acc_lo} >> 1
                        acc_hi_q <= sum_d[32:1];
                        acc_lo_q <= {sum_d[0], acc_lo_q[31:1]};
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 6'd1;
                        if (cnt_q == LAST_CNT) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
`ifdef MULT_EARLY_EXIT_EN
                    end
`endif
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The accumulator doubles as the product register: it is only cleared by
    // LOAD, so the last result stays put throughout IDLE.
    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = acc_hi_q;
    assign product_lo = acc_lo_q;

endmodule

// File: tb/tb_mult32_controller.sv
// tb/tb_mult32_controller.sv - scoreboard bench for mult32_controller

module tb_mult32_controller;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    mult32_controller #(.ITER(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] last_prod;
    int          cyc;
    int          n_checks;
    int          n_pass;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic and the latency rule.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        longint unsigned px = longint'(x);
        longint unsigned py = longint'(y);
        return 64'(px * py);
    endfunction

    function automatic int ref_lat(input logic [31:0] y);
`ifdef MULT_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < 32; i++) if (y[i]) msb = i;
        if (msb < 0) return 3;
        return (4 + msb > 34) ? 34 : 4 + msb;
`else
        return 34 + 0 * int'(y[0]);
`endif
    endfunction

    // Monitor: pops the scoreboard on each done pulse; otherwise checks
    // busy against the model and product stability while idle.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("product", {product_hi, product_lo}, e.prod);
                    chk("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                    chk("busy_at_done", 64'(busy), 64'd1);
                    last_prod = e.prod;
                end
            end else if (sb_q.size() != 0) begin
                chk("busy_in_op", 64'(busy), 64'd1);
            end else begin
                chk("busy_idle", 64'(busy), 64'd0);
                chk("idle_hold", {product_hi, product_lo}, last_prod);
            end
        end
    end

    // Waits for the model queue to drain, then launches one multiply.
    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        exp_t e;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("issue_timeout", 64'd1, 64'd0);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        e.prod    = ref_prod(x, y);
        e.acc_cyc = cyc;
        e.lat     = ref_lat(y);
        sb_q.push_back(e);
        // Operands are don't-care after acceptance.
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    logic [31:0] ta [0:7];
    logic [31:0] tb_ [0:7];

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0; last_prod = '0;
        a = 32'h1234; b = 32'h5678;
        // Reset with start held high: reset must win.
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", {product_hi, product_lo}, 64'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed operands including boundaries and carry cases.
        ta[0] = 32'd5;        tb_[0] = 32'd7;
        ta[1] = 32'hFFFFFFFF; tb_[1] = 32'hFFFFFFFF;
        ta[2] = 32'h12345678; tb_[2] = 32'd0;
        ta[3] = 32'h12345678; tb_[3] = 32'd1;
        ta[4] = 32'd0;        tb_[4] = 32'hDEADBEEF;
        ta[5] = 32'h80000000; tb_[5] = 32'hFFFFFFFF;
        ta[6] = 32'hFFFFFFFF; tb_[6] = 32'h80000000;
        ta[7] = 32'h00010000; tb_[7] = 32'h00010000;
        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb_[i]);
            drain();
            repeat (3) @(posedge clk);
            #1;
        end

        // Back-to-back: 0x10000^2 then 2x3, a short idle gap between.
        issue(32'h00010000, 32'h00010000);
        drain();
        repeat (4) @(posedge clk);
        #1;
        issue(32'd2, 32'd3);
        drain();

        // start pulses during an active 3x4 must be ignored.
        issue(32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'hAAAAAAAA; b = 32'h55555555; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        drain();
        repeat (40) @(posedge clk);
        #1;

        // Abort at T+15 with reset; no done may appear.
        issue(32'hCAFEF00D, 32'h0BADBEEF);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb_q.delete();
        last_prod = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_product", {product_hi, product_lo}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        issue(32'd9, 32'd11);
        drain();

        // Randomized operands.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] rx, ry;
            rx = $urandom;
            ry = $urandom;
            if (i % 5 == 1) ry = ry >> $urandom_range(31, 0);
            issue(rx, ry);
            if ($urandom_range(1, 0) == 1) drain();
        end
        drain();
        repeat (5) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
